// File: rtl/spi_ram_arb_pkg.sv
// Shared widths and types for the SPI / modem frame-RAM arbiter.
// Used by spi_ram_arbiter and spi_ram_arb_rdret.
package spi_ram_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_SPI  = 2'd1,
        OWN_MDM  = 2'd2
    } owner_e;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/spi_ram_arb_rdret.sv
// Read-return path: delays the {owner, read} tag by one cycle to line up
// with the RAM output, then captures and steers the data to its requester.
module spi_ram_arb_rdret
    import spi_ram_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        owner_i,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [DATA_W-1:0] spi_rdata_o,
    output logic              mdm_rvalid_o,
    output logic [DATA_W-1:0] mdm_rdata_o
);

    owner_e            tag_owner_q, tag_owner_d;
    logic              tag_rd_q, tag_rd_d;
    logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
    logic [DATA_W-1:0] mdm_rdata_q, mdm_rdata_d;
    logic              mdm_rvalid_q, mdm_rvalid_d;

    always_comb begin
        tag_owner_d  = owner_e'(owner_i);
        tag_rd_d     = rd_i;
        spi_rdata_d  = spi_rdata_q;
        mdm_rdata_d  = mdm_rdata_q;
        mdm_rvalid_d = 1'b0;
        // The tag describes the command the RAM answered last cycle.
        if (tag_rd_q) begin
            case (tag_owner_q)
                OWN_SPI: spi_rdata_d = ram_rdata_i;
                OWN_MDM: begin
                    mdm_rdata_d  = ram_rdata_i;
                    mdm_rvalid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_owner_q  <= OWN_IDLE;
            tag_rd_q     <= 1'b0;
            spi_rdata_q  <= '0;
            mdm_rdata_q  <= '0;
            mdm_rvalid_q <= 1'b0;
        end else begin
            tag_owner_q  <= tag_owner_d;
            tag_rd_q     <= tag_rd_d;
            spi_rdata_q  <= spi_rdata_d;
            mdm_rdata_q  <= mdm_rdata_d;
            mdm_rvalid_q <= mdm_rvalid_d;
        end
    end

    assign spi_rdata_o  = spi_rdata_q;
    assign mdm_rvalid_o = mdm_rvalid_q;
    assign mdm_rdata_o  = mdm_rdata_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Single-port frame-RAM arbiter: SPI strobes always win, modem uses req/gnt.
// Optional conflict statistics enabled by defining SPI_RAM_ARB_STATS_EN.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
(
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_spi_wr,
    input  logic              i_spi_rd,
    input  logic [ADDR_W-1:0] i_spi_addr,
    input  logic [DATA_W-1:0] i_spi_wdata,
    output logic [DATA_W-1:0] o_spi_rdata,
    input  logic              i_mdm_req,
    input  logic              i_mdm_we,
    input  logic [ADDR_W-1:0] i_mdm_addr,
    input  logic [DATA_W-1:0] i_mdm_wdata,
    output logic              o_mdm_gnt,
    output logic              o_mdm_rvalid,
    output logic [DATA_W-1:0] o_mdm_rdata,
`ifdef SPI_RAM_ARB_STATS_EN
    input  logic              i_stats_clr,
    output logic [15:0]       o_conflict_cnt,
`endif
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    // Handshake: the modem holds req/we/addr/wdata stable until a cycle in
    // which o_mdm_gnt=1; that cycle is the transfer and the command issues.
    logic     spi_strobe;
    owner_e   owner_q, owner_d;
    ram_cmd_t cmd_q, cmd_d;

    assign spi_strobe = i_spi_wr | i_spi_rd;
    assign o_mdm_gnt  = i_mdm_req & ~spi_strobe;

    // owner_q names whoever owns the command currently on o_ram_*.
    always_comb begin
        owner_d = OWN_IDLE;
        cmd_d   = '0;
        if (spi_strobe) begin
            owner_d     = OWN_SPI;
            cmd_d.en    = 1'b1;
            cmd_d.we    = i_spi_wr;
            cmd_d.addr  = i_spi_addr;
            cmd_d.wdata = i_spi_wdata;
        end else if (i_mdm_req) begin
            owner_d     = OWN_MDM;
            cmd_d.en    = 1'b1;
            cmd_d.we    = i_mdm_we;
            cmd_d.addr  = i_mdm_addr;
            cmd_d.wdata = i_mdm_wdata;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q <= OWN_IDLE;
            cmd_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
        end
    end

    assign o_ram_en    = cmd_q.en;
    assign o_ram_we    = cmd_q.we;
    assign o_ram_addr  = cmd_q.addr;
    assign o_ram_wdata = cmd_q.wdata;

    spi_ram_arb_rdret u_rdret (
        .clk_i        (i_sys_clk),
        .rst_ni       (i_rst_n),
        .owner_i      (owner_q),
        .rd_i         (cmd_q.en & ~cmd_q.we),
        .ram_rdata_i  (i_ram_rdata),
        .spi_rdata_o  (o_spi_rdata),
        .mdm_rvalid_o (o_mdm_rvalid),
        .mdm_rdata_o  (o_mdm_rdata)
    );

`ifdef SPI_RAM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (i_stats_clr) begin
            conflict_cnt_d = '0;
        end else if (i_mdm_req && !o_mdm_gnt && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign o_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: RAM model, transaction-level
// reference model with per-cycle compare, directed scenarios and random traffic.
module tb_spi_ram_arbiter;
    import spi_ram_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              i_spi_wr, i_spi_rd;
    logic [ADDR_W-1:0] i_spi_addr;
    logic [DATA_W-1:0] i_spi_wdata;
    logic [DATA_W-1:0] o_spi_rdata;
    logic              i_mdm_req, i_mdm_we;
    logic [ADDR_W-1:0] i_mdm_addr;
    logic [DATA_W-1:0] i_mdm_wdata;
    logic              o_mdm_gnt, o_mdm_rvalid;
    logic [DATA_W-1:0] o_mdm_rdata;
    logic              o_ram_en, o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
`ifdef SPI_RAM_ARB_STATS_EN
    logic              i_stats_clr;
    logic [15:0]       o_conflict_cnt;
`endif

    spi_ram_arbiter dut (
        .i_sys_clk    (clk),
        .i_rst_n      (rst_n),
        .i_spi_wr     (i_spi_wr),
        .i_spi_rd     (i_spi_rd),
        .i_spi_addr   (i_spi_addr),
        .i_spi_wdata  (i_spi_wdata),
        .o_spi_rdata  (o_spi_rdata),
        .i_mdm_req    (i_mdm_req),
        .i_mdm_we     (i_mdm_we),
        .i_mdm_addr   (i_mdm_addr),
        .i_mdm_wdata  (i_mdm_wdata),
        .o_mdm_gnt    (o_mdm_gnt),
        .o_mdm_rvalid (o_mdm_rvalid),
        .o_mdm_rdata  (o_mdm_rdata),
`ifdef SPI_RAM_ARB_STATS_EN
        .i_stats_clr    (i_stats_clr),
        .o_conflict_cnt (o_conflict_cnt),
`endif
        .o_ram_en     (o_ram_en),
        .o_ram_we     (o_ram_we),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    // ---------------- synchronous RAM model ----------------
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_we) ram_mem[o_ram_addr] <= o_ram_wdata;
            else          ram_rdata <= ram_mem[o_ram_addr];
        end
    end

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One record per issued command; hist[k] was issued k+1 cycles ago.
    typedef struct {
        bit                valid;
        bit                spi;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    op_t               hist [3];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] exp_spi_rdata = '0;
    logic [DATA_W-1:0] exp_mdm_rdata = '0;
    logic [15:0]       exp_cnt = '0;

    function automatic op_t no_op();
        op_t o;
        o.valid = 1'b0; o.spi = 1'b0; o.we = 1'b0; o.addr = '0; o.data = '0;
        return o;
    endfunction

    always @(negedge clk) begin
        op_t now_op;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] = no_op();
            exp_spi_rdata = '0;
            exp_mdm_rdata = '0;
            exp_cnt       = '0;
            chk("rst_ram_en",    32'(o_ram_en),     32'd0);
            chk("rst_rvalid",    32'(o_mdm_rvalid), 32'd0);
            chk("rst_spi_rdata", 32'(o_spi_rdata),  32'd0);
            chk("rst_mdm_rdata", 32'(o_mdm_rdata),  32'd0);
        end else begin
            chk("gnt", 32'(o_mdm_gnt), 32'(i_mdm_req && !(i_spi_wr || i_spi_rd)));
            chk("ram_en", 32'(o_ram_en), 32'(hist[0].valid));
            if (hist[0].valid) begin
                chk("ram_we",   32'(o_ram_we),   32'(hist[0].we));
                chk("ram_addr", 32'(o_ram_addr), 32'(hist[0].addr));
                if (hist[0].we) chk("ram_wdata", 32'(o_ram_wdata), 32'(hist[0].data));
            end
            if (hist[2].valid && !hist[2].we) begin
                if (hist[2].spi) exp_spi_rdata = hist[2].data;
                else             exp_mdm_rdata = hist[2].data;
            end
            chk("mdm_rvalid", 32'(o_mdm_rvalid), 32'(hist[2].valid && !hist[2].we && !hist[2].spi));
            chk("spi_rdata",  32'(o_spi_rdata),  32'(exp_spi_rdata));
            chk("mdm_rdata",  32'(o_mdm_rdata),  32'(exp_mdm_rdata));
`ifdef SPI_RAM_ARB_STATS_EN
            chk("conflict_cnt", 32'(o_conflict_cnt), 32'(exp_cnt));
            if (i_stats_clr) exp_cnt = '0;
            else if (i_mdm_req && (i_spi_wr || i_spi_rd) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            now_op = no_op();
            if (i_spi_wr || i_spi_rd) begin
                now_op.valid = 1'b1; now_op.spi = 1'b1; now_op.we = i_spi_wr;
                now_op.addr  = i_spi_addr;
                now_op.data  = i_spi_wr ? i_spi_wdata : shadow[i_spi_addr];
            end else if (i_mdm_req) begin
                now_op.valid = 1'b1; now_op.spi = 1'b0; now_op.we = i_mdm_we;
                now_op.addr  = i_mdm_addr;
                now_op.data  = i_mdm_we ? i_mdm_wdata : shadow[i_mdm_addr];
            end
            if (now_op.valid && now_op.we) shadow[now_op.addr] = now_op.data;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = now_op;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        i_spi_wr = 1'b0; i_spi_rd = 1'b0; i_spi_addr = '0; i_spi_wdata = '0;
        i_mdm_req = 1'b0; i_mdm_we = 1'b0; i_mdm_addr = '0; i_mdm_wdata = '0;
`ifdef SPI_RAM_ARB_STATS_EN
        i_stats_clr = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic spi_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        step();
        i_spi_wr = 1'b1; i_spi_addr = a; i_spi_wdata = d;
    endtask

    task automatic spi_read(input logic [ADDR_W-1:0] a);
        step();
        i_spi_rd = 1'b1; i_spi_addr = a;
    endtask

    task automatic mdm_drive(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        i_mdm_req = 1'b1; i_mdm_we = we; i_mdm_addr = a; i_mdm_wdata = d;
    endtask

    // Time limit on the whole run.
    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic              pend, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    int                rv_cnt, r;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) spi_write(ADDR_W'(i), DATA_W'($urandom));
        spi_write(10'd5, 8'h5E);

        // Reset lands while an SPI read is in flight.
        spi_read(10'd5);
        step();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrd_ram_en", 32'(o_ram_en), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("midrd_spi_rdata", 32'(o_spi_rdata), 32'd0);
        chk("midrd_rvalid",    32'(o_mdm_rvalid), 32'd0);

        // Top-of-range write/read with exact latency.
        spi_write(10'h3FF, 8'hA5);
        spi_read(10'h3FF);
        step();
        step();
        @(negedge clk);
        chk("lat_before", 32'(o_spi_rdata), 32'd0);
        step();
        @(negedge clk);
        chk("lat_3ff", 32'(o_spi_rdata), 32'hA5);

        // Modem read held while SPI writes addr 3 four cycles running.
        for (int k = 1; k <= 4; k++) begin
            spi_write(10'd3, DATA_W'(k));
            mdm_drive(1'b0, 10'd3, 8'h00);
            @(negedge clk);
            chk("held_gnt_low", 32'(o_mdm_gnt), 32'd0);
        end
        step();
        mdm_drive(1'b0, 10'd3, 8'h00);
        @(negedge clk);
        chk("held_gnt_5th", 32'(o_mdm_gnt), 32'd1);
        step();
        step();
        @(negedge clk);
        chk("held_rvalid_early", 32'(o_mdm_rvalid), 32'd0);
        step();
        @(negedge clk);
        chk("held_rvalid", 32'(o_mdm_rvalid), 32'd1);
        chk("held_rdata",  32'(o_mdm_rdata),  32'h04);

        // Modem write followed next cycle by SPI read of the same byte.
        step();
        mdm_drive(1'b1, 10'd7, 8'h3C);
        @(negedge clk);
        chk("coll_gnt", 32'(o_mdm_gnt), 32'd1);
        spi_read(10'd7);
        step();
        step();
        @(negedge clk);
        chk("coll_before", 32'(o_spi_rdata), 32'hA5);
        step();
        @(negedge clk);
        chk("coll_spi_rdata", 32'(o_spi_rdata), 32'h3C);

        // Alternating SPI and modem reads must never swap data.
        spi_write(10'd1, 8'h11);
        spi_write(10'd2, 8'h22);
        rv_cnt = 0;
        for (int k = 0; k <= 10; k++) begin
            step();
            if (k < 8) begin
                if (k % 2 == 0) begin
                    i_spi_rd = 1'b1; i_spi_addr = 10'd1;
                end else begin
                    mdm_drive(1'b0, 10'd2, 8'h00);
                end
            end
            @(negedge clk);
            if (o_mdm_rvalid) begin
                rv_cnt++;
                chk("il_mdm_rdata", 32'(o_mdm_rdata), 32'h22);
            end
            if (k >= 3) chk("il_spi_rdata", 32'(o_spi_rdata), 32'h11);
        end
        chk("il_rvalid_count", 32'(rv_cnt), 32'd4);

        // Random traffic over a small address window to force collisions.
        pend = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        for (int n = 0; n < 3000; n++) begin
            step();
            r = $urandom_range(0, 3);
            if (r == 0) begin
                i_spi_wr = 1'b1; i_spi_addr = ADDR_W'($urandom_range(0, 15)); i_spi_wdata = DATA_W'($urandom);
            end else if (r == 1) begin
                i_spi_rd = 1'b1; i_spi_addr = ADDR_W'($urandom_range(0, 15));
            end
            if (!pend) begin
                pend    = 1'($urandom_range(0, 1));
                m_we    = 1'($urandom_range(0, 1));
                m_addr  = ADDR_W'($urandom_range(0, 15));
                m_wdata = DATA_W'($urandom);
            end
            if (pend) mdm_drive(m_we, m_addr, m_wdata);
`ifdef SPI_RAM_ARB_STATS_EN
            i_stats_clr = ($urandom_range(0, 49) == 0);
`endif
            @(negedge clk);
            if (o_mdm_gnt) pend = 1'b0;
        end
        if (pend) begin
            step();
            mdm_drive(m_we, m_addr, m_wdata);
        end

`ifdef SPI_RAM_ARB_STATS_EN
        step();
        i_stats_clr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            spi_write(10'd20, DATA_W'(k));
            mdm_drive(1'b0, 10'd20, 8'h00);
        end
        step();
        mdm_drive(1'b0, 10'd20, 8'h00);
        @(negedge clk);
        chk("stats_ten", 32'(o_conflict_cnt), 32'd10);
        spi_write(10'd20, 8'h00);
        mdm_drive(1'b0, 10'd20, 8'h00);
        i_stats_clr = 1'b1;
        step();
        @(negedge clk);
        chk("stats_clr_wins", 32'(o_conflict_cnt), 32'd0);
        for (int k = 0; k < 65540; k++) begin
            spi_write(10'd20, DATA_W'(k));
            mdm_drive(1'b0, 10'd20, 8'h00);
        end
        step();
        mdm_drive(1'b0, 10'd20, 8'h00);
        @(negedge clk);
        chk("stats_sat", 32'(o_conflict_cnt), 32'hFFFF);
        step();
        i_stats_clr = 1'b1;
        step();
        @(negedge clk);
        chk("stats_clr", 32'(o_conflict_cnt), 32'd0);
`endif

        repeat (5) step();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
